xgs_line_pattern_gen: RTL and testbench

XGS_LINE_PATTERN_GEN -- requirements
Module: xgs_line_pattern_gen

---
 rtl/xgs_pattern_pkg.sv | 22 ++
 rtl/xgs_pattern_beat.sv | 39 +++
 rtl/xgs_line_pattern_gen.sv | 203 ++++++++++++++++++++
 tb/tb_xgs_line_pattern_gen.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgs_pattern_pkg.sv
// Shared types for the line pattern generator: FSM state, pattern select and
// the default stream beat width.
// Latency: n/a (types only). Backpressure: n/a.
package xgs_pattern_pkg;

  localparam int XGS_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  // Code 3 is reserved and is rendered as the ramp.
  typedef enum logic [1:0] {
    PAT_RAMP    = 2'd0,
    PAT_CONST   = 2'd1,
    PAT_FRAMEID = 2'd2,
    PAT_RSVD    = 2'd3
  } pat_e;

endpackage

// File: rtl/xgs_pattern_beat.sv
// Purpose: forms one 32-bit beat (4 pixels x 8 bit) from pattern, position and ids.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller holds the inputs stable while a beat is stalled.
//
// Ports:
//   pattern  - pattern select (ramp / constant / frame-id, reserved = ramp)
//   x, y     - beat index within the line, line index within the frame
//   cval     - byte for the constant pattern
//   frame_id - byte for the frame-id pattern
//   beat     - formed beat, byte 0 in bits [7:0]
module xgs_pattern_beat
  import xgs_pattern_pkg::*;
#(
  parameter int CNT_WIDTH = 12
) (
  input  pat_e                 pattern,
  input  logic [CNT_WIDTH-1:0] x,
  input  logic [CNT_WIDTH-1:0] y,
  input  logic [7:0]           cval,
  input  logic [7:0]           frame_id,
  output logic [31:0]          beat
);

  always_comb begin
    beat = '0;
    case (pattern)
      PAT_CONST:   beat = {4{cval}};
      PAT_FRAMEID: beat = {4{frame_id}};
      default: begin
        // Byte i of beat x on line y is (4x + i + y) mod 256; the 8-bit cast
        // performs the modulo.
        for (int i = 0; i < 4; i++) begin
          beat[8*i +: 8] = 8'((32'(x) << 2) + 32'(y) + 32'(i));
        end
      end
    endcase
  end

endmodule

// File: rtl/xgs_line_pattern_gen.sv
// Purpose: generates test frames (ramp / constant / frame-id) on an AXI-Stream master.
// Latency: first beat valid 1 cycle after an accepted start; done 1 cycle after the last handshake.
// Backpressure: beats advance only on tvalid & tready; tdata/tuser/tlast are held while stalled.
//
// Ports:
//   sclk, sclk_reset_n             - clock, asynchronous active-low reset
//   start, abort                   - single-cycle frame request / stop request
//   cfg_x_size, cfg_y_size         - beats per line, lines per frame (latched at start)
//   cfg_line_gap                   - idle cycles between lines
//   cfg_pattern, cfg_const         - pattern select and constant byte
//   m_axis_*                       - registered stream output (tuser = SOF, tlast = EOL)
//   busy, done, cfg_err, frame_cnt - status: in frame, frame complete, rejected start, completed frames
module xgs_line_pattern_gen
  import xgs_pattern_pkg::*;
#(
  parameter int DATA_WIDTH = XGS_DATA_WIDTH,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                  sclk,
  input  logic                  sclk_reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  cfg_x_size,
  input  logic [CNT_WIDTH-1:0]  cfg_y_size,
  input  logic [7:0]            cfg_line_gap,
  input  logic [1:0]            cfg_pattern,
  input  logic [7:0]            cfg_const,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [15:0]           frame_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] x_q, x_nxt, y_q, y_nxt;
  logic [CNT_WIDTH-1:0] xs_q, xs_nxt, ys_q, ys_nxt;
  logic [7:0]           gap_q, gap_nxt, gap_cnt_q, gap_cnt_nxt;
  pat_e                 pat_q, pat_nxt;
  logic [7:0]           const_q, const_nxt, fid_q, fid_nxt;
  logic                 abort_pend_q, abort_pend_nxt;
  logic                 done_q, done_nxt, err_q, err_nxt;
  logic [15:0]          frame_cnt_q, frame_cnt_nxt;
  logic                 tvalid_q, tuser_q, tlast_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                 tvalid_nxt, tuser_nxt, tlast_nxt;
  logic [DATA_WIDTH-1:0] tdata_nxt;
  logic [31:0]          beat;
  logic                 hs, last_beat, last_line;

  assign hs        = tvalid_q & m_axis_tready;
  assign last_beat = (x_q == xs_q - CNT_ONE);
  assign last_line = (y_q == ys_q - CNT_ONE);

  always_comb begin
    state_nxt      = state_q;
    x_nxt          = x_q;
    y_nxt          = y_q;
    xs_nxt         = xs_q;
    ys_nxt         = ys_q;
    gap_nxt        = gap_q;
    gap_cnt_nxt    = gap_cnt_q;
    pat_nxt        = pat_q;
    const_nxt      = const_q;
    fid_nxt        = fid_q;
    abort_pend_nxt = abort_pend_q;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    frame_cnt_nxt  = frame_cnt_q;
    case (state_q)
      IDLE: begin
        // Abort outranks a simultaneous start.
        if (start && !abort) begin
          if ((cfg_x_size != '0) && (cfg_y_size != '0)) begin
            state_nxt      = ACTIVE;
            x_nxt          = '0;
            y_nxt          = '0;
            xs_nxt         = cfg_x_size;
            ys_nxt         = cfg_y_size;
            gap_nxt        = cfg_line_gap;
            pat_nxt        = pat_e'(cfg_pattern);
            const_nxt      = cfg_const;
            fid_nxt        = frame_cnt_q[7:0];
            abort_pend_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (abort) abort_pend_nxt = 1'b1;
        if (hs) begin
          // An abort seen with or before this handshake lets the beat go out,
          // then ends the frame without a done.
          if (abort || abort_pend_q) begin
            state_nxt      = IDLE;
            abort_pend_nxt = 1'b0;
          end else if (last_beat) begin
            x_nxt = '0;
            if (last_line) begin
              state_nxt     = IDLE;
              done_nxt      = 1'b1;
              frame_cnt_nxt = frame_cnt_q + 16'd1;
            end else begin
              y_nxt = y_q + CNT_ONE;
              if (gap_q != 8'd0) begin
                state_nxt   = GAP;
                gap_cnt_nxt = gap_q - 8'd1;
              end
            end
          end else begin
            x_nxt = x_q + CNT_ONE;
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (gap_cnt_q == 8'd0) begin
          state_nxt = ACTIVE;
        end else begin
          gap_cnt_nxt = gap_cnt_q - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The beat is formed from next-cycle values so the output stage is a plain register.
  xgs_pattern_beat #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_beat (
    .pattern  (pat_nxt),
    .x        (x_nxt),
    .y        (y_nxt),
    .cval     (const_nxt),
    .frame_id (fid_nxt),
    .beat     (beat)
  );

  assign tvalid_nxt = (state_nxt == ACTIVE);
  assign tdata_nxt  = tvalid_nxt ? beat : '0;
  assign tuser_nxt  = tvalid_nxt && (x_nxt == '0) && (y_nxt == '0);
  assign tlast_nxt  = tvalid_nxt && (x_nxt == xs_nxt - CNT_ONE);

  always_ff @(posedge sclk or negedge sclk_reset_n) begin
    if (!sclk_reset_n) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      xs_q         <= '0;
      ys_q         <= '0;
      gap_q        <= '0;
      gap_cnt_q    <= '0;
      pat_q        <= PAT_RAMP;
      const_q      <= '0;
      fid_q        <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
      tvalid_q     <= 1'b0;
      tdata_q      <= '0;
      tuser_q      <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      x_q          <= x_nxt;
      y_q          <= y_nxt;
      xs_q         <= xs_nxt;
      ys_q         <= ys_nxt;
      gap_q        <= gap_nxt;
      gap_cnt_q    <= gap_cnt_nxt;
      pat_q        <= pat_nxt;
      const_q      <= const_nxt;
      fid_q        <= fid_nxt;
      abort_pend_q <= abort_pend_nxt;
      done_q       <= done_nxt;
      err_q        <= err_nxt;
      frame_cnt_q  <= frame_cnt_nxt;
      tvalid_q     <= tvalid_nxt;
      tdata_q      <= tdata_nxt;
      tuser_q      <= tuser_nxt;
      tlast_q      <= tlast_nxt;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cfg_err       = err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_xgs_line_pattern_gen.sv
// Bench for xgs_line_pattern_gen: directed scenarios plus randomized frames,
// each checked against a frame model built from position/pattern arithmetic.
// Latency: n/a. Backpressure: tready driven per scenario (steady, toggling, random).
module tb_xgs_line_pattern_gen;

  logic        sclk = 1'b0;
  logic        sclk_reset_n;
  logic        start, abort;
  logic [11:0] cfg_x_size, cfg_y_size;
  logic [7:0]  cfg_line_gap;
  logic [1:0]  cfg_pattern;
  logic [7:0]  cfg_const;
  logic        m_axis_tvalid, m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast;
  logic        busy, done, cfg_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int          cyc = 0;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  int          hs_cyc[$];
  int          n_done, n_err, n_busy, n_valid, n_stall_viol, n_done_busy, done_cyc;
  bit          stall_prev = 1'b0;
  logic [33:0] stall_dat;
  logic [15:0] exp_fc;

  xgs_line_pattern_gen #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (12)
  ) dut (
    .sclk          (sclk),
    .sclk_reset_n  (sclk_reset_n),
    .start         (start),
    .abort         (abort),
    .cfg_x_size    (cfg_x_size),
    .cfg_y_size    (cfg_y_size),
    .cfg_line_gap  (cfg_line_gap),
    .cfg_pattern   (cfg_pattern),
    .cfg_const     (cfg_const),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .frame_cnt     (frame_cnt)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    cyc++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      hs_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      if (busy !== 1'b0) n_done_busy++;
    end
    if (cfg_err === 1'b1) n_err++;
    if (busy === 1'b1) n_busy++;
    if (m_axis_tvalid === 1'b1) n_valid++;
    if (stall_prev && (m_axis_tvalid !== 1'b1 ||
        {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== stall_dat)) n_stall_viol++;
    stall_prev = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
    stall_dat  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_beat(int pat, int x, int y, logic [7:0] c, logic [7:0] fid);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      if (pat == 1)      b[8*i +: 8] = c;
      else if (pat == 2) b[8*i +: 8] = fid;
      else               b[8*i +: 8] = 8'((4 * x + i + y) % 256);
    end
    return b;
  endfunction

  task automatic build_exp(input int xs, input int ys, input int pat, input logic [7:0] c, input logic [7:0] fid);
    exp_q.delete();
    for (int yy = 0; yy < ys; yy++)
      for (int xx = 0; xx < xs; xx++)
        exp_q.push_back({(xx == 0 && yy == 0) ? 1'b1 : 1'b0, (xx == xs - 1) ? 1'b1 : 1'b0,
                         ref_beat(pat, xx, yy, c, fid)});
  endtask

  // ---------------- drivers ----------------
  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic clear_mon;
    got_q.delete();
    hs_cyc.delete();
    n_done = 0; n_err = 0; n_busy = 0; n_valid = 0;
    n_stall_viol = 0; n_done_busy = 0; done_cyc = -1;
  endtask

  task automatic drive_ready(input int mode, input int k);
    case (mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (k % 2 == 0);
      default: m_axis_tready = ($urandom % 4 != 0);
    endcase
  endtask

  task automatic scramble_cfg;
    cfg_x_size   = 12'($urandom);
    cfg_y_size   = 12'($urandom);
    cfg_line_gap = 8'($urandom);
    cfg_pattern  = 2'($urandom);
    cfg_const    = 8'($urandom);
  endtask

  task automatic do_reset;
    sclk_reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; m_axis_tready = 1'b0;
    repeat (3) tick();
    sclk_reset_n = 1'b1;
    tick();
    exp_fc = 16'd0;
  endtask

  // Starts a frame, then runs until done or the cycle budget expires. cfg_* are
  // scrambled after the start; optionally start is re-pulsed while busy.
  task automatic run_frame(input int xs, input int ys, input int gap, input int pat,
                           input logic [7:0] cv, input int mode, input bit poke,
                           output bit timed_out, output logic busy_seen);
    int k;
    clear_mon();
    cfg_x_size = 12'(xs); cfg_y_size = 12'(ys); cfg_line_gap = 8'(gap);
    cfg_pattern = 2'(pat); cfg_const = cv;
    start = 1'b1;
    drive_ready(mode, 0);
    tick();
    start = 1'b0;
    busy_seen = busy;
    timed_out = 1'b1;
    k = 1;
    while (k < 4000) begin
      if (n_done > 0) begin
        timed_out = 1'b0;
        break;
      end
      drive_ready(mode, k);
      start = (poke && busy === 1'b1 && ($urandom % 6 == 0));
      scramble_cfg();
      tick();
      k++;
    end
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    sclk_reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; m_axis_tready = 1'b0;
    cfg_x_size = '0; cfg_y_size = '0; cfg_line_gap = '0; cfg_pattern = '0; cfg_const = '0;
    repeat (2) tick();
    checks++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== 3'b000) begin errors++;
      $display("FAIL reset_strobes: got %b want 000", {m_axis_tvalid, m_axis_tuser, m_axis_tlast}); end
    checks++; if (m_axis_tdata !== 32'h0) begin errors++;
      $display("FAIL reset_tdata: got %h want 00000000", m_axis_tdata); end
    checks++; if ({busy, done, cfg_err} !== 3'b000) begin errors++;
      $display("FAIL reset_status: got %b want 000", {busy, done, cfg_err}); end
    checks++; if (frame_cnt !== 16'h0) begin errors++;
      $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
    sclk_reset_n = 1'b1;
    tick();
    exp_fc = 16'd0;
  endtask

  task automatic test_ramp_gap;
    bit to; logic bs;
    build_exp(4, 2, 0, 8'h00, 8'h00);
    run_frame(4, 2, 3, 0, 8'h00, 0, 1'b0, to, bs);
    if (!to) exp_fc = exp_fc + 16'd1;
    checks++; if (to) begin errors++; $display("FAIL ramp_timeout: no done within budget"); end
    checks++; if (bs !== 1'b1) begin errors++; $display("FAIL ramp_busy_after_start: got %b want 1", bs); end
    checks++; if (got_q.size() != 8) begin errors++;
      $display("FAIL ramp_beat_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL ramp_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() >= 5) begin
      checks++; if (got_q[0][31:0] !== 32'h03020100 || got_q[1][31:0] !== 32'h07060504) begin errors++;
        $display("FAIL ramp_line0_data: got %h %h want 03020100 07060504", got_q[0][31:0], got_q[1][31:0]); end
      checks++; if (got_q[4][31:0] !== 32'h04030201) begin errors++;
        $display("FAIL ramp_line1_first: got %h want 04030201", got_q[4][31:0]); end
      checks++; if (hs_cyc[4] - hs_cyc[3] - 1 != 3) begin errors++;
        $display("FAIL ramp_gap_cycles: got %0d want 3", hs_cyc[4] - hs_cyc[3] - 1); end
    end
    checks++; if (n_done != 1 || n_done_busy != 0) begin errors++;
      $display("FAIL ramp_done_pulse: got %0d cycles (busy-high %0d) want 1 (0)", n_done, n_done_busy); end
    if (got_q.size() > 0) begin
      checks++; if (done_cyc != hs_cyc[hs_cyc.size() - 1] + 1) begin errors++;
        $display("FAIL ramp_done_timing: got cycle %0d want %0d", done_cyc, hs_cyc[hs_cyc.size() - 1] + 1); end
    end
    tick();
    checks++; if (frame_cnt !== exp_fc || exp_fc !== 16'd1) begin errors++;
      $display("FAIL ramp_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_const_stall;
    bit to; logic bs;
    build_exp(3, 1, 1, 8'hA5, 8'h00);
    run_frame(3, 1, 0, 1, 8'hA5, 1, 1'b0, to, bs);
    if (!to) exp_fc = exp_fc + 16'd1;
    checks++; if (to || got_q.size() != 3) begin errors++;
      $display("FAIL const_beat_count: got %0d (timeout %0d) want 3", got_q.size(), to); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL const_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (n_stall_viol != 0) begin errors++;
      $display("FAIL const_stall_stable: got %0d changes during stalls want 0", n_stall_viol); end
    tick();
    checks++; if (frame_cnt !== exp_fc) begin errors++;
      $display("FAIL const_frame_cnt: got %0d want %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_cfg_err;
    int xv[2] = '{0, 7};
    int yv[2] = '{5, 0};
    for (int t = 0; t < 2; t++) begin
      clear_mon();
      cfg_x_size = 12'(xv[t]); cfg_y_size = 12'(yv[t]); cfg_pattern = 2'd0;
      m_axis_tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      checks++; if (n_err != 1) begin errors++;
        $display("FAIL cfg_err_pulse[%0d]: got %0d cycles want 1", t, n_err); end
      checks++; if (n_busy != 0 || n_valid != 0) begin errors++;
        $display("FAIL cfg_err_idle[%0d]: got busy %0d valid %0d want 0 0", t, n_busy, n_valid); end
    end
    // Abort beats a simultaneous start in IDLE.
    clear_mon();
    cfg_x_size = 12'd2; cfg_y_size = 12'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (5) tick();
    checks++; if (n_busy != 0 || n_valid != 0 || n_err != 0) begin errors++;
      $display("FAIL start_abort_same_cycle: got busy %0d valid %0d err %0d want 0 0 0", n_busy, n_valid, n_err); end
  endtask

  task automatic test_abort;
    int k;
    logic [31:0] want;
    clear_mon();
    want = ref_beat(0, 4, 1, 8'h00, 8'h00);
    cfg_x_size = 12'd16; cfg_y_size = 12'd4; cfg_line_gap = 8'd2;
    cfg_pattern = 2'd0; cfg_const = 8'h00;
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (got_q.size() < 20 && k < 500) begin tick(); k++; end
    checks++; if (got_q.size() != 20) begin errors++;
      $display("FAIL abort_reach_beat20: got %0d beats want 20", got_q.size()); end
    m_axis_tready = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== want) begin errors++;
      $display("FAIL abort_pending_beat: got valid %b data %h want 1 %h", m_axis_tvalid, m_axis_tdata, want); end
    m_axis_tready = 1'b1;
    repeat (6) tick();
    checks++; if (got_q.size() != 21) begin errors++;
      $display("FAIL abort_beat_count: got %0d want 21", got_q.size()); end
    if (got_q.size() >= 21) begin
      checks++; if (got_q[20][31:0] !== want) begin errors++;
        $display("FAIL abort_beat20_data: got %h want %h", got_q[20][31:0], want); end
    end
    checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL abort_idle: got valid %b busy %b want 0 0", m_axis_tvalid, busy); end
    checks++; if (n_done != 0 || frame_cnt !== exp_fc) begin errors++;
      $display("FAIL abort_no_done: got done %0d frame_cnt %0d want 0 %0d", n_done, frame_cnt, exp_fc); end
  endtask

  task automatic test_frameid_b2b;
    bit to; logic bs;
    int xs, ys, breaks;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      xs = $urandom_range(2, 5);
      ys = $urandom_range(1, 3);
      build_exp(xs, ys, 2, 8'($urandom), 8'(f));
      run_frame(xs, ys, 0, 2, 8'h5C, 0, 1'b0, to, bs);
      if (!to) exp_fc = exp_fc + 16'd1;
      checks++; if (to || got_q.size() != exp_q.size()) begin errors++;
        $display("FAIL fid_count[%0d]: got %0d want %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++;
          $display("FAIL fid_beat[%0d][%0d]: got %h want %h", f, i, got_q[i], exp_q[i]); end
      end
      breaks = 0;
      for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 1) breaks++;
      checks++; if (breaks != 0) begin errors++;
        $display("FAIL fid_continuous[%0d]: got %0d breaks want 0", f, breaks); end
    end
    tick();
    checks++; if (frame_cnt !== 16'd3 || exp_fc !== 16'd3) begin errors++;
      $display("FAIL fid_frame_cnt: got %0d want 3", frame_cnt); end
  endtask

  task automatic test_reset_mid_line;
    bit to; logic bs;
    int k;
    clear_mon();
    cfg_x_size = 12'd8; cfg_y_size = 12'd2; cfg_line_gap = 8'd0; cfg_pattern = 2'd0;
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (got_q.size() < 3 && k < 50) begin tick(); k++; end
    #2;
    sclk_reset_n = 1'b0;
    #1;
    checks++; if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, done, cfg_err} !== 6'b0) begin errors++;
      $display("FAIL midreset_strobes: got %b want 000000",
               {m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy, done, cfg_err}); end
    checks++; if (m_axis_tdata !== 32'h0 || frame_cnt !== 16'h0) begin errors++;
      $display("FAIL midreset_data: got %h %h want 0 0", m_axis_tdata, frame_cnt); end
    tick();
    sclk_reset_n = 1'b1;
    tick();
    exp_fc = 16'd0;
    build_exp(2, 2, 0, 8'h00, 8'h00);
    run_frame(2, 2, 1, 0, 8'h00, 2, 1'b0, to, bs);
    if (!to) exp_fc = exp_fc + 16'd1;
    checks++; if (to || got_q.size() != 4) begin errors++;
      $display("FAIL midreset_new_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++;
        $display("FAIL midreset_new_beat[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random;
    bit to; logic bs;
    int xs, ys, gap, pat;
    logic [7:0] cv;
    for (int f = 0; f < 6; f++) begin
      xs = $urandom_range(1, 7); ys = $urandom_range(1, 3);
      gap = $urandom_range(0, 3); pat = $urandom_range(0, 3);
      cv = 8'($urandom);
      build_exp(xs, ys, pat, cv, exp_fc[7:0]);
      run_frame(xs, ys, gap, pat, cv, 2, 1'b1, to, bs);
      if (!to) exp_fc = exp_fc + 16'd1;
      checks++; if (to || got_q.size() != exp_q.size()) begin errors++;
        $display("FAIL rand_count[%0d]: got %0d want %0d", f, got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++;
          $display("FAIL rand_beat[%0d][%0d]: got %h want %h", f, i, got_q[i], exp_q[i]); end
      end
      checks++; if (n_err != 0 || n_stall_viol != 0) begin errors++;
        $display("FAIL rand_status[%0d]: got err %0d stall changes %0d want 0 0", f, n_err, n_stall_viol); end
      tick();
      checks++; if (frame_cnt !== exp_fc) begin errors++;
        $display("FAIL rand_frame_cnt[%0d]: got %0d want %0d", f, frame_cnt, exp_fc); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_gap();
    test_const_stall();
    test_cfg_err();
    test_abort();
    test_frameid_b2b();
    test_reset_mid_line();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
